// File: rtl/write_back_stage_if.sv
// MEM/WB stage bus: memory-stage instruction fields in, register-file write port and retire count out.
interface write_back_stage_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
);
  logic                  in_valid;
  logic                  stall;
  logic                  flush;
  logic                  in_reg_write;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [1:0]            in_wb_sel;
  logic [XLEN-1:0]       in_alu_result;
  logic [XLEN-1:0]       in_mem_data;
  logic [XLEN-1:0]       in_pc_plus4;
  logic [XLEN-1:0]       in_imm;
  logic [2:0]            in_funct3;
  logic [1:0]            in_byte_off;

  logic                  wb_valid;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic [CNT_W-1:0]      retire_cnt;

  modport master (
    output in_valid, stall, flush, in_reg_write, in_rd, in_wb_sel,
           in_alu_result, in_mem_data, in_pc_plus4, in_imm, in_funct3, in_byte_off,
    input  wb_valid, wb_reg_write, wb_rd, wb_data, retire_cnt
  );

  modport slave (
    input  in_valid, stall, flush, in_reg_write, in_rd, in_wb_sel,
           in_alu_result, in_mem_data, in_pc_plus4, in_imm, in_funct3, in_byte_off,
    output wb_valid, wb_reg_write, wb_rd, wb_data, retire_cnt
  );
endinterface

// File: rtl/write_back_stage.sv
// MEM/WB pipeline register with write-back result selection and retired-instruction counter.
// Define WB_LOAD_EXT_EN to extract and sign/zero-extend sub-word loads; otherwise loads pass raw.
module write_back_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  write_back_stage_if.slave  bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  logic [XLEN-1:0] load_data_c;
  logic [XLEN-1:0] sel_data_c;

`ifdef WB_LOAD_EXT_EN
  logic [BYTE_W-1:0] load_byte_c;
  logic [HALF_W-1:0] load_half_c;

  // Sub-word extraction; halfwords ignore byte_off[0]
  always_comb begin
    load_byte_c = bus.in_mem_data[7:0];
    load_half_c = bus.in_mem_data[15:0];
    load_data_c = bus.in_mem_data;
    case (bus.in_byte_off)
      2'd0:    load_byte_c = bus.in_mem_data[7:0];
      2'd1:    load_byte_c = bus.in_mem_data[15:8];
      2'd2:    load_byte_c = bus.in_mem_data[23:16];
      default: load_byte_c = bus.in_mem_data[31:24];
    endcase
    if (bus.in_byte_off[1]) begin
      load_half_c = bus.in_mem_data[31:16];
    end
    case (bus.in_funct3)
      3'b000:  load_data_c = {{(XLEN-BYTE_W){load_byte_c[BYTE_W-1]}}, load_byte_c};
      3'b001:  load_data_c = {{(XLEN-HALF_W){load_half_c[HALF_W-1]}}, load_half_c};
      3'b100:  load_data_c = {{(XLEN-BYTE_W){1'b0}}, load_byte_c};
      3'b101:  load_data_c = {{(XLEN-HALF_W){1'b0}}, load_half_c};
      default: load_data_c = bus.in_mem_data;
    endcase
  end
`else
  logic unused_load_ctrl;

  // Memory stage delivers aligned words; load type and offset are not needed here
  assign unused_load_ctrl = ^{bus.in_funct3, bus.in_byte_off};
  assign load_data_c      = bus.in_mem_data;
`endif

  // Result source select ahead of the pipeline register
  always_comb begin
    sel_data_c = bus.in_alu_result;
    case (bus.in_wb_sel)
      2'b00: sel_data_c = bus.in_alu_result;
      2'b01: sel_data_c = load_data_c;
      2'b10: sel_data_c = bus.in_pc_plus4;
      2'b11: sel_data_c = bus.in_imm;
    endcase
  end

  // Priority: reset > flush > stall > capture
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.wb_valid     <= 1'b0;
      bus.wb_reg_write <= 1'b0;
      bus.wb_rd        <= '0;
      bus.wb_data      <= '0;
      bus.retire_cnt   <= '0;
    end else if (bus.flush) begin
      bus.wb_valid     <= 1'b0;
      bus.wb_reg_write <= 1'b0;
      bus.wb_rd        <= '0;
      bus.wb_data      <= '0;
    end else if (!bus.stall) begin
      bus.wb_valid     <= bus.in_valid;
      bus.wb_reg_write <= bus.in_valid & bus.in_reg_write & (bus.in_rd != '0);
      bus.wb_rd        <= bus.in_rd;
      bus.wb_data      <= sel_data_c;
      if (bus.in_valid) begin
        bus.retire_cnt <= bus.retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule
